// File: rtl/ps2_scancode_fifo.sv
// PS/2 scancode event FIFO.
// Synchronizes the keyboard controller's frame-done strobe and detects its
// rising edge. E0/F0 prefix bytes are folded into one 10-bit event
// {brk, ext, code}, and events are buffered in a first-word-fall-through FIFO.
// irq is asserted while the FIFO holds at least one event.
module ps2_scancode_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    kb_data,
  input  logic          kb_valid,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic [9:0]    dout,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          irq,
  output logic          ovf,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  logic          r_s1, r_s2, r_s3;
  logic          w_evt;
  state_t        r_state;
  logic          r_wr_req;
  logic [9:0]    r_wr_data;
  logic          r_err;
  logic          r_ovf;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_push, w_pop;
  logic          w_brk, w_ext;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= kb_valid;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_evt = r_s2 & ~r_s3;
  assign w_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

  // Prefix parser. Produces a registered write request one cycle after the
  // byte event. Error set is ordered after the clear so a set takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_req  <= 1'b0;
      r_wr_data <= 10'h000;
      r_err     <= 1'b0;
    end else begin
      r_wr_req <= 1'b0;
      if (clr_err) r_err <= 1'b0;
      if (w_evt) begin
        case (kb_data)
          8'hE0: begin
            if (r_state == ST_IDLE)     r_state <= ST_EXT;
            else if (r_state == ST_BRK) r_state <= ST_EXT_BRK;
          end
          8'hF0: begin
            if (r_state == ST_IDLE)     r_state <= ST_BRK;
            else if (r_state == ST_EXT) r_state <= ST_EXT_BRK;
          end
          8'h00, 8'hFF: begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: begin
            r_wr_req  <= 1'b1;
            r_wr_data <= {w_brk, w_ext, kb_data};
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push  = r_wr_req & (~w_full | w_pop);

  // Storage array; no reset so it maps onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_wr_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (clr_err) r_ovf <= 1'b0;
      if (r_wr_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign dout  = w_empty ? 10'h000 : r_mem[r_rptr];
  assign empty = w_empty;
  assign count = r_count;
  assign irq   = ~w_empty;
  assign ovf   = r_ovf;
  assign err   = r_err;

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Sits directly downstream of the PS/2 keyboard controller.
- Consumes its 8-bit frame byte and its frame-done strobe.
- Folds E0/F0 prefix bytes into single key events and buffers the events in a FIFO.
- The CPU I/O bus reads the FIFO; the block raises a level interrupt while events are pending.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, minimum 2
CW, 5, width of count output; equals log2(DEPTH)+1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
kb_data  input  8  byte from keyboard controller; stable while kb_valid is high and until the next frame
kb_valid  input  1  frame-done strobe from keyboard controller; asynchronous to clk, width unknown
rd_en  input  1  CPU pop request, one entry per clk cycle it is high
clr_err  input  1  clears the sticky ovf and err flags
dout  output  10  head entry {brk, ext, code[7:0]}; first-word-fall-through
empty  output  1  FIFO holds no entries
count  output  CW  number of entries held, 0..DEPTH
irq  output  1  equals !empty
ovf  output  1  sticky: an event was dropped because the FIFO was full
err  output  1  sticky: byte 0x00 or 0xFF (keyboard overrun/error) received

Behaviour:
- Reset (synchronous, rst high at posedge):
  - FIFO pointers cleared; count=0, empty=1, irq=0.
  - ovf=0, err=0; parser returns to IDLE.
  - Synchronizer flops and the edge-detect flop cleared.
  - dout=0.
  - Reset mid-sequence discards any pending prefix.
- Input capture:
  - kb_valid passes through two flops (s1, s2), then a third flop (s3).
  - A byte event occurs in the cycle where s2=1 and s3=0.
  - Exactly one event per low-to-high transition of kb_valid, however long it stays high.
  - kb_data is sampled in the event cycle.
- Latency: if kb_valid is first sampled high at edge N, the FIFO write takes effect at edge N+3; empty falls and count increments after that edge.
- Parser FSM, updated only on byte events; states IDLE, EXT, BRK, EXT_BRK:
  - 0xE0: IDLE->EXT, BRK->EXT_BRK, otherwise unchanged; no write.
  - 0xF0: IDLE->BRK, EXT->EXT_BRK, otherwise unchanged; no write.
  - 0x00 or 0xFF: set err, return to IDLE, no write.
  - Any other byte, including 0xE1, 0xAA and 0xFA: write {brk, ext, byte}, where brk=1 in BRK/EXT_BRK and ext=1 in EXT/EXT_BRK; return to IDLE.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - count tracks occupancy: +1 on an accepted write, -1 on an accepted read, unchanged if both happen in the same cycle.
  - dout shows the entry at the read pointer whenever empty=0, and 0 when empty=1.
  - rd_en while empty: ignored; pointers and count unchanged.
  - Write while count==DEPTH and no pop in the same cycle: entry dropped, ovf set, parser still returns to IDLE.
  - Write while full with rd_en in the same cycle: pop and write both accepted; count stays DEPTH; ovf unchanged.
  - Write and pop in the same cycle while count==1: write accepted; the next head is the new entry; empty stays 0.
- Flags:
  - ovf and err stay set until clr_err or rst.
  - If clr_err and a new set condition occur in the same cycle, set wins.

Test Plan:
1. kb_data=0x1C with a 1-cycle kb_valid pulse -> after 3 edges: empty=0, count=1, irq=1, dout=0x01C; one rd_en cycle -> empty=1, dout=0x000, irq=0.
2. Bytes E0, F0, 74, each with its own kb_valid pulse -> exactly one entry, dout=0x374; bytes F0, 1C -> next entry 0x21C; E0, 75 -> 0x175.
3. kb_valid held high for 20 cycles with kb_data=0x29 -> count=1; pulses separated by 3 low cycles -> one entry per pulse.
4. DEPTH=4, write codes 0x10..0x14 with no reads -> count=4, ovf=1, pops return 0x010..0x013 in order; clr_err -> ovf=0.
5. FIFO full (DEPTH=4) with rd_en asserted in the write cycle of 0x55 -> count stays 4, ovf=0, the last pop returns 0x055; rd_en while empty -> count stays 0, dout=0x000.
6. Send E0, assert rst for one cycle, then send 1C -> entry 0x01C; send 0xFF -> err=1, no entry written.
